register_file: RTL and testbench
================================

# register_file

Architectural register file with rename tags. It sits downstream of the reorder buffer: it consumes ROB commits (value, rd id and ROB tag) and clears pending tags on mispredict flush. At issue time it serves two combinational read ports to instruction fetch/issue: a value if the register is settled, or the ROB tag of the youngest in-flight producer.

## Interface
- ROB_WIDTH, 4, width of ROB tags; must match the ROB.
- clk_in  input  1  system clock; all state updates on the rising edge.
- rst_in  input  1  reset; synchronous, active-low.
- rdy_in  input  1  state is frozen while low; reads remain live.
- clear_signal  input  1  mispredict flush from the ROB.
- issue_signal  input  1  an instruction is being issued this cycle.
- issue_rd_id  input  5  destination register of the issued instruction.
- issue_rob_tag  input  ROB_WIDTH  ROB line allocated to the issued instruction.
- reg_done  input  1  ROB commit to the register file.
- reg_id  input  5  committed rd.
- reg_value  input  32  committed value.
- reg_tag  input  ROB_WIDTH  ROB line of the committed instruction.
- rs1_id, rs2_id  input  5 each  source register ids (combinational lookup).
- rs1_value, rs2_value  output  32 each  register value, or the bypassed commit value.
- rs1_busy, rs2_busy  output  1 each  1 means the value is pending; use the tag.
- rs1_tag, rs2_tag  output  ROB_WIDTH each  ROB tag of the pending producer.

## Operation
- State per register i (1..31): value[i] (32), busy[i], tag[i] (ROB_WIDTH). x0 has no storage: it reads value 0, busy 0, tag 0, and all writes to it are ignored.
- Reset (rst_in==0 at an edge): all values 0, all busy 0, all tags 0. Reset takes priority over every other input.
- With rdy_in==0, no state changes.
- Commit (reg_done, reg_id!=0):
  - value[reg_id] <= reg_value.
  - busy[reg_id] is cleared only if busy[reg_id] && tag[reg_id]==reg_tag. A younger producer keeps the register busy.
- Issue (issue_signal && !clear_signal && issue_rd_id!=0): busy[rd] <= 1, tag[rd] <= issue_rob_tag.
- Commit and issue to the same rd in one cycle:
  - the value is written;
  - busy stays 1;
  - the tag becomes issue_rob_tag, because issue wins over the commit clear.
- clear_signal:
  - all busy bits go to 0;
  - a commit in the same cycle still writes its value (the ROB asserts clear together with a JALR commit);
  - issue is ignored.
- Read port, for each rsN:
  - if rsN_id==0, output 0/0/0;
  - otherwise output value/busy/tag from state, as modified by the bypass under Configuration.
  - Same-cycle issue does not affect reads: an instruction sees the state from before its own rd rename.

## Timing
- Reads are purely combinational from current state and commit inputs; there are zero cycles of latency.
- Commit and issue writes become visible on read ports one cycle after the edge.
- Flush completes in one cycle. The read ports show busy==0 for every register from the cycle after the clear edge.
- Tag values wrap modulo 2^ROB_WIDTH. Only exact equality is compared; there is no age ordering.

## Configuration
- RF_COMMIT_BYPASS_EN defined:
  - if reg_done && reg_id==rsN_id!=0 && busy[rsN_id] && tag[rsN_id]==reg_tag, the port outputs rsN_value=reg_value and rsN_busy=0 in the same cycle;
  - this avoids a one-cycle window in which the issued instruction waits on a tag that the ROB has already retired.
- Undefined: ports reflect registered state only. In that case the ROB's broadcast to the reservation stations must cover the gap.

## Structure
- Shared package rf_pkg: NUM_ARCH_REGS=32, REG_ID_WIDTH=5, XLEN=32, the ROB_WIDTH default, and a read-result typedef {value, busy, tag}.
- One sub-module, rf_read_port, instantiated twice. It holds the x0 check and the optional bypass mux.

## Test plan
- Reset, then read rs1=5 and rs2=0 -> value 0, busy 0, tag 0 on both ports.
- Issue rd=5, tag 3; next cycle rs1=5 -> busy 1, tag 3. Commit rd=5, tag 3, value 0xDEADBEEF; next cycle -> busy 0, value 0xDEADBEEF.
- Issue rd=7 tag 2, then issue rd=7 tag 4. Commit rd=7 tag 2, value 0x11 -> value 0x11, busy 1, tag 4. Commit tag 4, value 0x22 -> busy 0, value 0x22.
- Same cycle: commit rd=9 tag 1, value 0xAB, and issue rd=9 tag 6 -> next cycle value 0xAB, busy 1, tag 6.
- Registers 3 and 8 busy. Assert clear with commit rd=3, value 0x55, and issue rd=10 -> next cycle all busy 0, value[3]=0x55, reg 10 not busy.
- With RF_COMMIT_BYPASS_EN: reg 12 busy with tag 5; in one cycle commit rd=12 tag 5, value 0x77 and read rs2=12 -> the same cycle shows rs2_value=0x77, rs2_busy=0. Without the macro -> busy 1, tag 5.

Source files
------------

// File: rtl/rf_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rf_pkg
// Description : Shared constants and types for the architectural register
//               file: register count, id width, datapath width, the default
//               ROB tag width, and the read-result record {value, busy, tag}.
// Revision    : 1.0 - initial release
// ============================================================================
package rf_pkg;

  localparam int NUM_ARCH_REGS     = 32;
  localparam int REG_ID_WIDTH      = 5;
  localparam int XLEN              = 32;
  localparam int DEFAULT_ROB_WIDTH = 4;

  // What a read port returns for one source operand.
  typedef struct packed {
    logic [XLEN-1:0]              value;
    logic                         busy;
    logic [DEFAULT_ROB_WIDTH-1:0] tag;
  } rf_read_t;

endpackage : rf_pkg
`default_nettype wire

// File: rtl/rf_read_port.sv
`default_nettype none
// ============================================================================
// Module      : rf_read_port
// Description : One combinational source-operand read port. Forces x0 to
//               0/0/0 and, when RF_COMMIT_BYPASS_EN is defined, forwards a
//               same-cycle commit that retires the register's pending tag.
// Ports       : rs_id                          - source register id
//               state_value/busy/tag           - registered state of rs_id
//               reg_done/id/value/tag          - commit inputs (bypass build)
//               rs_value/rs_busy/rs_tag        - operand result
// Config      : RF_COMMIT_BYPASS_EN (optional commit-to-read bypass)
// Revision    : 1.0 - initial release
// ============================================================================
module rf_read_port
  import rf_pkg::*;
#(
  parameter int ROB_WIDTH = DEFAULT_ROB_WIDTH
) (
  input  logic [REG_ID_WIDTH-1:0] rs_id,
  input  logic [XLEN-1:0]         state_value,
  input  logic                    state_busy,
  input  logic [ROB_WIDTH-1:0]    state_tag,
`ifdef RF_COMMIT_BYPASS_EN
  input  logic                    reg_done,
  input  logic [REG_ID_WIDTH-1:0] reg_id,
  input  logic [XLEN-1:0]         reg_value,
  input  logic [ROB_WIDTH-1:0]    reg_tag,
`endif
  output logic [XLEN-1:0]         rs_value,
  output logic                    rs_busy,
  output logic [ROB_WIDTH-1:0]    rs_tag
);

  logic w_is_x0;
  assign w_is_x0 = (rs_id == '0);

`ifdef RF_COMMIT_BYPASS_EN
  // Only a commit that would actually clear busy may be forwarded; an older
  // producer's commit must not hide a younger pending rename.
  logic w_bypass_hit;
  assign w_bypass_hit = reg_done && (reg_id == rs_id) && !w_is_x0 &&
                        state_busy && (state_tag == reg_tag);
`endif

  always_comb begin
    rs_value = state_value;
    rs_busy  = state_busy;
    rs_tag   = state_tag;
    if (w_is_x0) begin
      rs_value = '0;
      rs_busy  = 1'b0;
      rs_tag   = '0;
    end
`ifdef RF_COMMIT_BYPASS_EN
    else if (w_bypass_hit) begin
      rs_value = reg_value;
      rs_busy  = 1'b0;
    end
`endif
  end

endmodule : rf_read_port
`default_nettype wire

// File: rtl/register_file.sv
`default_nettype none
// ============================================================================
// Module      : register_file
// Description : Architectural register file with rename tags. Takes ROB
//               commits (value/rd/tag), records issue-time renames, clears
//               all pending tags on mispredict flush, and serves two
//               combinational read ports (value, or tag of youngest producer).
// Ports       : clk_in, rst_in (sync, active-low), rdy_in (freeze when low)
//               clear_signal                     - mispredict flush
//               issue_signal/issue_rd_id/issue_rob_tag - rename at issue
//               reg_done/reg_id/reg_value/reg_tag      - ROB commit
//               rs1_*/rs2_*                      - read ports
// Config      : RF_COMMIT_BYPASS_EN - forward retiring commit to read ports
// Revision    : 1.0 - initial release
// ============================================================================
module register_file
  import rf_pkg::*;
#(
  parameter int ROB_WIDTH = DEFAULT_ROB_WIDTH
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic                    rdy_in,
  input  logic                    clear_signal,
  input  logic                    issue_signal,
  input  logic [REG_ID_WIDTH-1:0] issue_rd_id,
  input  logic [ROB_WIDTH-1:0]    issue_rob_tag,
  input  logic                    reg_done,
  input  logic [REG_ID_WIDTH-1:0] reg_id,
  input  logic [XLEN-1:0]         reg_value,
  input  logic [ROB_WIDTH-1:0]    reg_tag,
  input  logic [REG_ID_WIDTH-1:0] rs1_id,
  input  logic [REG_ID_WIDTH-1:0] rs2_id,
  output logic [XLEN-1:0]         rs1_value,
  output logic [XLEN-1:0]         rs2_value,
  output logic                    rs1_busy,
  output logic                    rs2_busy,
  output logic [ROB_WIDTH-1:0]    rs1_tag,
  output logic [ROB_WIDTH-1:0]    rs2_tag
);

  // Flat views of the state for the read muxes; entry 0 is a hard zero.
  logic [XLEN-1:0]          w_state_value [NUM_ARCH_REGS];
  logic [NUM_ARCH_REGS-1:0] w_state_busy;
  logic [ROB_WIDTH-1:0]     w_state_tag   [NUM_ARCH_REGS];

  // A flush cancels any rename arriving in the same cycle.
  logic w_issue_en;
  assign w_issue_en = issue_signal && !clear_signal;

  assign w_state_value[0] = '0;
  assign w_state_busy[0]  = 1'b0;
  assign w_state_tag[0]   = '0;

  generate
    for (genvar gi = 1; gi < NUM_ARCH_REGS; gi++) begin : g_reg
      logic [XLEN-1:0]      r_value;
      logic                 r_busy;
      logic [ROB_WIDTH-1:0] r_tag;
      logic                 w_commit_hit;
      logic                 w_issue_hit;
      logic                 w_commit_retires;

      assign w_commit_hit     = reg_done && (reg_id == REG_ID_WIDTH'(gi));
      assign w_issue_hit      = w_issue_en && (issue_rd_id == REG_ID_WIDTH'(gi));
      // Commit frees the register only if it is the youngest producer.
      assign w_commit_retires = w_commit_hit && r_busy && (r_tag == reg_tag);

      always_ff @(posedge clk_in) begin
        if (!rst_in) begin
          r_value <= '0;
          r_busy  <= 1'b0;
          r_tag   <= '0;
        end else if (rdy_in) begin
          if (w_commit_hit) begin
            r_value <= reg_value;
          end
          // Priority: flush, then new rename, then commit retirement.
          if (clear_signal) begin
            r_busy <= 1'b0;
          end else if (w_issue_hit) begin
            r_busy <= 1'b1;
          end else if (w_commit_retires) begin
            r_busy <= 1'b0;
          end
          if (w_issue_hit) begin
            r_tag <= issue_rob_tag;
          end
        end
      end

      assign w_state_value[gi] = r_value;
      assign w_state_busy[gi]  = r_busy;
      assign w_state_tag[gi]   = r_tag;
    end
  endgenerate

  rf_read_port #(
    .ROB_WIDTH   (ROB_WIDTH)
  ) u_rs1_port (
    .rs_id       (rs1_id),
    .state_value (w_state_value[rs1_id]),
    .state_busy  (w_state_busy[rs1_id]),
    .state_tag   (w_state_tag[rs1_id]),
`ifdef RF_COMMIT_BYPASS_EN
    .reg_done    (reg_done),
    .reg_id      (reg_id),
    .reg_value   (reg_value),
    .reg_tag     (reg_tag),
`endif
    .rs_value    (rs1_value),
    .rs_busy     (rs1_busy),
    .rs_tag      (rs1_tag)
  );

  rf_read_port #(
    .ROB_WIDTH   (ROB_WIDTH)
  ) u_rs2_port (
    .rs_id       (rs2_id),
    .state_value (w_state_value[rs2_id]),
    .state_busy  (w_state_busy[rs2_id]),
    .state_tag   (w_state_tag[rs2_id]),
`ifdef RF_COMMIT_BYPASS_EN
    .reg_done    (reg_done),
    .reg_id      (reg_id),
    .reg_value   (reg_value),
    .reg_tag     (reg_tag),
`endif
    .rs_value    (rs2_value),
    .rs_busy     (rs2_busy),
    .rs_tag      (rs2_tag)
  );

endmodule : register_file
`default_nettype wire

// File: tb/tb_register_file.sv
`default_nettype none
// ============================================================================
// Module      : tb_register_file
// Description : Self-checking bench for register_file: directed scenarios
//               with literal expectations, then randomized traffic checked
//               against a behavioural register-file model.
// Config      : honours RF_COMMIT_BYPASS_EN for expected read results
// Revision    : 1.0 - initial release
// ============================================================================
module tb_register_file;
  import rf_pkg::*;

  logic        clk_in = 1'b0;
  logic        rst_in, rdy_in, clear_signal, issue_signal, reg_done;
  logic [4:0]  issue_rd_id, reg_id, rs1_id, rs2_id;
  logic [3:0]  issue_rob_tag, reg_tag, rs1_tag, rs2_tag;
  logic [31:0] reg_value, rs1_value, rs2_value;
  logic        rs1_busy, rs2_busy;

  int tests = 0;
  int fails = 0;

  // Behavioural model of architectural state (index 0 never written).
  logic [31:0] m_value [32];
  logic        m_busy  [32];
  logic [3:0]  m_tag   [32];

  register_file #(.ROB_WIDTH(4)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
    .clear_signal(clear_signal), .issue_signal(issue_signal),
    .issue_rd_id(issue_rd_id), .issue_rob_tag(issue_rob_tag),
    .reg_done(reg_done), .reg_id(reg_id), .reg_value(reg_value), .reg_tag(reg_tag),
    .rs1_id(rs1_id), .rs2_id(rs2_id),
    .rs1_value(rs1_value), .rs2_value(rs2_value),
    .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
    .rs1_tag(rs1_tag), .rs2_tag(rs2_tag)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", name, obs, exp);
    end
  endtask

  function automatic rf_read_t exp_read(input logic [4:0] id);
    rf_read_t r;
    r = '0;
    if (id != 5'd0) begin
      r.value = m_value[id];
      r.busy  = m_busy[id];
      r.tag   = m_tag[id];
`ifdef RF_COMMIT_BYPASS_EN
      if (reg_done && reg_id == id && m_busy[id] && m_tag[id] == reg_tag) begin
        r.value = reg_value;
        r.busy  = 1'b0;
      end
`endif
    end
    return r;
  endfunction

  // Apply one clock edge of architectural rules to the model.
  task automatic model_update();
    if (!rst_in) begin
      for (int i = 0; i < 32; i++) begin
        m_value[i] = '0; m_busy[i] = 1'b0; m_tag[i] = '0;
      end
    end else if (rdy_in) begin
      if (reg_done && reg_id != 5'd0) begin
        m_value[reg_id] = reg_value;
        if (m_busy[reg_id] && m_tag[reg_id] == reg_tag) m_busy[reg_id] = 1'b0;
      end
      if (clear_signal) begin
        for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
      end else if (issue_signal && issue_rd_id != 5'd0) begin
        m_busy[issue_rd_id] = 1'b1;
        m_tag[issue_rd_id]  = issue_rob_tag;
      end
    end
  endtask

  // Wait for the low phase and compare both ports with the model.
  task automatic sample();
    rf_read_t e1, e2;
    @(negedge clk_in);
    e1 = exp_read(rs1_id);
    e2 = exp_read(rs2_id);
    chk("rs1_value", rs1_value, e1.value);
    chk("rs1_busy",  {31'd0, rs1_busy}, {31'd0, e1.busy});
    chk("rs1_tag",   {28'd0, rs1_tag},  {28'd0, e1.tag});
    chk("rs2_value", rs2_value, e2.value);
    chk("rs2_busy",  {31'd0, rs2_busy}, {31'd0, e2.busy});
    chk("rs2_tag",   {28'd0, rs2_tag},  {28'd0, e2.tag});
  endtask

  task automatic tick();
    @(posedge clk_in);
    model_update();
    #1;
  endtask

  task automatic idle();
    rdy_in = 1'b1; clear_signal = 1'b0; issue_signal = 1'b0; reg_done = 1'b0;
    issue_rd_id = '0; issue_rob_tag = '0; reg_id = '0; reg_value = '0; reg_tag = '0;
  endtask

  task automatic do_issue(input logic [4:0] rd, input logic [3:0] tag);
    issue_signal = 1'b1; issue_rd_id = rd; issue_rob_tag = tag;
  endtask

  task automatic do_commit(input logic [4:0] rd, input logic [3:0] tag, input logic [31:0] val);
    reg_done = 1'b1; reg_id = rd; reg_tag = tag; reg_value = val;
  endtask

  initial begin
    idle();
    rs1_id = '0; rs2_id = '0;
    rst_in = 1'b0;
    tick(); tick();
    rst_in = 1'b1;

    // Reset state
    rs1_id = 5'd5; rs2_id = 5'd0;
    sample();
    chk("rst_rs1_value", rs1_value, 32'd0);
    chk("rst_rs1_busy", {31'd0, rs1_busy}, 32'd0);
    chk("rst_rs2_tag", {28'd0, rs2_tag}, 32'd0);
    tick();

    // Rename then retire
    do_issue(5'd5, 4'd3); sample(); tick();
    idle(); sample();
    chk("iss5_busy", {31'd0, rs1_busy}, 32'd1);
    chk("iss5_tag", {28'd0, rs1_tag}, 32'd3);
    tick();
    do_commit(5'd5, 4'd3, 32'hDEADBEEF); sample();
`ifdef RF_COMMIT_BYPASS_EN
    chk("byp5_busy", {31'd0, rs1_busy}, 32'd0);
    chk("byp5_value", rs1_value, 32'hDEADBEEF);
`else
    chk("nobyp5_busy", {31'd0, rs1_busy}, 32'd1);
`endif
    tick();
    idle(); sample();
    chk("cmt5_busy", {31'd0, rs1_busy}, 32'd0);
    chk("cmt5_value", rs1_value, 32'hDEADBEEF);
    tick();

    // Older commit must not clear a younger rename
    rs1_id = 5'd7;
    do_issue(5'd7, 4'd2); sample(); tick();
    do_issue(5'd7, 4'd4); sample(); tick();
    idle(); do_commit(5'd7, 4'd2, 32'h11); sample(); tick();
    idle(); sample();
    chk("old7_value", rs1_value, 32'h11);
    chk("old7_busy", {31'd0, rs1_busy}, 32'd1);
    chk("old7_tag", {28'd0, rs1_tag}, 32'd4);
    tick();
    do_commit(5'd7, 4'd4, 32'h22); sample(); tick();
    idle(); sample();
    chk("young7_busy", {31'd0, rs1_busy}, 32'd0);
    chk("young7_value", rs1_value, 32'h22);
    tick();

    // Commit and issue to the same rd together
    rs1_id = 5'd9;
    do_commit(5'd9, 4'd1, 32'hAB); do_issue(5'd9, 4'd6); sample(); tick();
    idle(); sample();
    chk("same9_value", rs1_value, 32'hAB);
    chk("same9_busy", {31'd0, rs1_busy}, 32'd1);
    chk("same9_tag", {28'd0, rs1_tag}, 32'd6);
    tick();

    // Flush with concurrent commit and issue
    do_issue(5'd3, 4'd1); sample(); tick();
    do_issue(5'd8, 4'd2); sample(); tick();
    idle(); clear_signal = 1'b1;
    do_commit(5'd3, 4'd7, 32'h55); do_issue(5'd10, 4'd5); sample(); tick();
    idle(); rs1_id = 5'd3; rs2_id = 5'd10; sample();
    chk("clr3_value", rs1_value, 32'h55);
    chk("clr3_busy", {31'd0, rs1_busy}, 32'd0);
    chk("clr10_busy", {31'd0, rs2_busy}, 32'd0);
    tick();
    for (int i = 1; i < 32; i++) begin
      rs1_id = 5'(i); sample();
      chk("clr_all_busy", {31'd0, rs1_busy}, 32'd0);
      tick();
    end

    // Same-cycle commit read of a pending register
    do_issue(5'd12, 4'd5); sample(); tick();
    idle(); rs2_id = 5'd12; do_commit(5'd12, 4'd5, 32'h77); sample();
`ifdef RF_COMMIT_BYPASS_EN
    chk("byp12_value", rs2_value, 32'h77);
    chk("byp12_busy", {31'd0, rs2_busy}, 32'd0);
`else
    chk("nobyp12_busy", {31'd0, rs2_busy}, 32'd1);
    chk("nobyp12_tag", {28'd0, rs2_tag}, 32'd5);
`endif
    tick();

    // Frozen when not ready; x0 ignores writes
    idle(); rdy_in = 1'b0; do_issue(5'd13, 4'd9); do_commit(5'd13, 4'd0, 32'h99); tick();
    idle(); do_commit(5'd0, 4'd0, 32'hFFFF_FFFF); do_issue(5'd0, 4'd7);
    rs1_id = 5'd13; rs2_id = 5'd0; sample();
    chk("frz13_busy", {31'd0, rs1_busy}, 32'd0);
    chk("frz13_value", rs1_value, 32'd0);
    tick();
    idle(); sample();
    chk("x0_value", rs2_value, 32'd0);
    chk("x0_busy", {31'd0, rs2_busy}, 32'd0);
    tick();

    // Randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      logic [4:0] rid;
      rst_in       = ($urandom % 200) != 0;
      rdy_in       = ($urandom % 10) != 0;
      clear_signal = ($urandom % 25) == 0;
      issue_signal = ($urandom % 2) == 1;
      issue_rd_id  = 5'($urandom);
      issue_rob_tag = 4'($urandom);
      reg_done     = ($urandom % 2) == 1;
      rid          = 5'($urandom % 12);
      reg_id       = rid;
      reg_value    = $urandom;
      reg_tag      = (($urandom % 3) != 0) ? m_tag[rid] : 4'($urandom);
      rs1_id       = (($urandom % 3) == 0) ? rid : 5'($urandom % 12);
      rs2_id       = (($urandom % 3) == 0) ? rid : 5'($urandom);
      sample();
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule : tb_register_file
`default_nettype wire
